// File: rtl/dst40_auth_reader.sv
// Reader-side DST40 challenge/response controller: issues an LFSR challenge to the
// link transmitter and the local cipher core, then compares the transponder response
// against the locally computed signature, with a bounded wait for both results.
module dst40_auth_reader #(
    parameter int              CH_W    = 40,
    parameter int              RSP_W   = 24,
    parameter logic [CH_W-1:0] SEED    = 40'h00_0000_0001,
    parameter int              TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic [CH_W-1:0]  chal,
    output logic             chal_valid,
    input  logic             chal_ready,
    input  logic [RSP_W-1:0] rsp,
    input  logic             rsp_valid,
    output logic             core_start,
    output logic [CH_W-1:0]  core_chal,
    input  logic [RSP_W-1:0] core_sig,
    input  logic             core_done,
    output logic             done,
    output logic             pass,
    output logic             timeout
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, CMP, DONE} state_t;

    state_t           state;
    logic [CH_W-1:0]  lfsr;
    logic [CH_W-1:0]  lfsr_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic [RSP_W-1:0] rsp_q;
    logic [RSP_W-1:0] sig_q;
    logic             r_got;
    logic             c_got;
    logic             r_take;
    logic             c_take;
    logic             r_got_nxt;
    logic             c_got_nxt;

    // The cipher core always sees the same challenge that goes out over the link
    assign core_chal = chal;

    // Next LFSR value, wait-counter increment and first-strobe capture qualifiers
    always_comb begin
        lfsr_next = {lfsr[CH_W-2:0], lfsr[39] ^ lfsr[37] ^ lfsr[20] ^ lfsr[18]};
        cnt_inc   = {1'b0, cnt} + 1'b1;
        r_take    = (state == WAIT) && rsp_valid && !r_got;
        c_take    = ((state == SEND) || (state == WAIT)) && core_done && !c_got;
        r_got_nxt = r_got | r_take;
        c_got_nxt = c_got | c_take;
    end

    // Authentication sequencer with registered outputs; a late strobe on the final
    // wait edge still counts because the capture flags are evaluated before the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= SEED;
            chal       <= '0;
            cnt        <= '0;
            rsp_q      <= '0;
            sig_q      <= '0;
            r_got      <= 1'b0;
            c_got      <= 1'b0;
            busy       <= 1'b0;
            chal_valid <= 1'b0;
            core_start <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr       <= lfsr_next;
                        chal       <= lfsr_next;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        r_got      <= 1'b0;
                        c_got      <= 1'b0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        chal_valid <= 1'b1;
                        core_start <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    core_start <= 1'b0;
                    if (c_take) begin
                        c_got <= 1'b1;
                        sig_q <= core_sig;
                    end
                    if (chal_ready) begin
                        chal_valid <= 1'b0;
                        cnt        <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_take) begin
                        r_got <= 1'b1;
                        rsp_q <= rsp;
                    end
                    if (c_take) begin
                        c_got <= 1'b1;
                        sig_q <= core_sig;
                    end
                    cnt <= cnt_inc[CNT_W-1:0];
                    if (r_got_nxt && c_got_nxt) begin
                        state <= CMP;
                    end else if (cnt_inc == TO_LIM) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                CMP: begin
                    pass  <= (rsp_q == sig_q);
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dst40_auth_reader.sv
// Self-checking bench for dst40_auth_reader: table of authentication scenarios with a
// done-driven scoreboard, plus hand-written reset and idle-strobe sequences.
module tb_dst40_auth_reader;

    localparam int              CH_W    = 40;
    localparam int              RSP_W   = 24;
    localparam int              TIMEOUT = 1000;
    localparam logic [CH_W-1:0] SEED    = 40'h00_0000_0001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic [CH_W-1:0]  chal;
    logic             chal_valid;
    logic             chal_ready;
    logic [RSP_W-1:0] rsp;
    logic             rsp_valid;
    logic             core_start;
    logic [CH_W-1:0]  core_chal;
    logic [RSP_W-1:0] core_sig;
    logic             core_done;
    logic             done;
    logic             pass;
    logic             timeout;

    dst40_auth_reader #(
        .CH_W(CH_W), .RSP_W(RSP_W), .SEED(SEED), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .chal(chal), .chal_valid(chal_valid), .chal_ready(chal_ready),
        .rsp(rsp), .rsp_valid(rsp_valid), .core_start(core_start),
        .core_chal(core_chal), .core_sig(core_sig), .core_done(core_done),
        .done(done), .pass(pass), .timeout(timeout)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0] e_chal;
        logic            e_pass;
        logic            e_to;
    } exp_t;

    typedef struct {
        logic [RSP_W-1:0] rsp_val;
        logic [RSP_W-1:0] sig_val;
        int               ready_wait;
        int               core_at;
        int               rsp_at;
        bit               give_rsp;
        bit               dup;
        bit               noise;
        bit               extra_start;
        logic [CH_W-1:0]  chal_lit;
        bit               exp_pass;
        bit               exp_to;
    } vec_t;

    exp_t            sb[$];
    vec_t            vecs[7];
    int              n_checks   = 0;
    int              n_fail     = 0;
    int              done_count = 0;
    logic [CH_W-1:0] model_lfsr;

    function automatic logic [CH_W-1:0] lfsr_step(input logic [CH_W-1:0] v);
        return {v[38:0], v[39] ^ v[37] ^ v[20] ^ v[18]};
    endfunction

    function automatic vec_t mk_vec(input logic [RSP_W-1:0] r, input logic [RSP_W-1:0] s,
                                    input int rw, input int ca, input int ra,
                                    input bit gr, input bit dp, input bit nz, input bit xs,
                                    input logic [CH_W-1:0] cl, input bit ep, input bit et);
        vec_t v;
        v.rsp_val = r;  v.sig_val = s;  v.ready_wait = rw; v.core_at = ca; v.rsp_at = ra;
        v.give_rsp = gr; v.dup = dp; v.noise = nz; v.extra_start = xs;
        v.chal_lit = cl; v.exp_pass = ep; v.exp_to = et;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        start      = 1'b0;
        chal_ready = 1'b0;
        rsp_valid  = 1'b0;
        rsp        = '0;
        core_done  = 1'b0;
        core_sig   = '0;
    endtask

    // Scoreboard: every done pulse retires the oldest expected result
    always @(posedge clk) begin
        #1;
        if (done) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_chal", chal, e.e_chal);
                checkOutput("sb_pass", pass, e.e_pass);
                checkOutput("sb_timeout", timeout, e.e_to);
            end
        end
    end

    // Global watchdog
    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input vec_t v);
        logic [CH_W-1:0] exp_chal;
        int exp_done_cyc;
        int cyc;
        int cs_count;
        int cv_count;
        int done_cyc;
        bit chal_stable;
        model_lfsr = lfsr_step(model_lfsr);
        exp_chal   = model_lfsr;
        sb.push_back('{e_chal: exp_chal, e_pass: v.exp_pass, e_to: v.exp_to});
        if (v.exp_to)
            exp_done_cyc = v.ready_wait + 1 + TIMEOUT;
        else
            exp_done_cyc = ((v.core_at > v.rsp_at) ? v.core_at : v.rsp_at) + 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("chal_model", chal, exp_chal);
        checkOutput("core_chal_model", core_chal, exp_chal);
        if (v.chal_lit != '0) checkOutput("chal_literal", chal, v.chal_lit);
        cyc = 0; cs_count = 0; cv_count = 0; done_cyc = -1; chal_stable = 1'b1;
        while (cyc <= exp_done_cyc + 5) begin
            if (core_start) cs_count++;
            if (chal_valid) begin
                cv_count++;
                if (chal !== exp_chal || core_chal !== exp_chal) chal_stable = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            chal_ready = (cyc >= v.ready_wait);
            core_done  = (cyc == v.core_at) || (v.dup && cyc == v.core_at + 1);
            core_sig   = (cyc == v.core_at) ? v.sig_val : ~v.sig_val;
            rsp_valid  = (v.give_rsp && (cyc == v.rsp_at || (v.dup && cyc == v.rsp_at + 1)))
                         || (v.noise && cyc == 0);
            rsp        = (v.give_rsp && cyc == v.rsp_at) ? v.rsp_val : (v.rsp_val ^ 24'h5A5A5A);
            start      = v.extra_start && (cyc % 3 == 1);
            tick();
            cyc++;
        end
        clearInputs();
        checkOutput("done_cycle", done_cyc, exp_done_cyc);
        checkOutput("core_start_pulses", cs_count, 1);
        checkOutput("chal_valid_cycles", cv_count, v.ready_wait + 1);
        checkOutput("chal_stable", chal_stable, 1);
        tick();
        checkOutput("busy_after_done", busy, 0);
        checkOutput("done_single_cycle", done, 0);
        checkOutput("pass_held", pass, v.exp_pass);
        checkOutput("timeout_held", timeout, v.exp_to);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_chal"}, chal, 0);
        checkOutput({tag, "_chal_valid"}, chal_valid, 0);
        checkOutput({tag, "_core_start"}, core_start, 0);
        checkOutput({tag, "_core_chal"}, core_chal, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_pass"}, pass, 0);
        checkOutput({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        int saved_done;
        //            rsp          sig         rdy core rsp  gr dp nz xs  chal_lit         pass to
        vecs[0] = mk_vec(24'hABCDEF, 24'hABCDEF, 0,  1,  51,  1, 0, 0, 0, 40'h00_0000_0002, 1, 0);
        vecs[1] = mk_vec(24'hABCDEE, 24'hABCDEF, 0,  3,  5,   1, 0, 0, 0, 40'h00_0000_0004, 0, 0);
        vecs[2] = mk_vec(24'h000000, 24'h123456, 5,  3,  0,   0, 0, 0, 0, '0,               0, 1);
        vecs[3] = mk_vec(24'h55AA33, 24'h55AA33, 10, 4,  15,  1, 0, 0, 0, '0,               1, 0);
        vecs[4] = mk_vec(24'h0F0F0F, 24'h0F0F0F, 0,  1,  1,   1, 0, 0, 1, '0,               1, 0);
        vecs[5] = mk_vec(24'h777777, 24'h777777, 2,  8,  4,   1, 1, 1, 1, '0,               1, 0);
        vecs[6] = mk_vec(24'h246810, 24'h246810, 0,  1,  TIMEOUT, 1, 0, 0, 0, '0,           1, 0);

        clearInputs();
        rst_n      = 1'b0;
        model_lfsr = SEED;
        repeat (3) tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();

        // Strobes while idle must not start anything
        rsp_valid = 1'b1; core_done = 1'b1; chal_ready = 1'b1;
        tick();
        clearInputs();
        tick();
        checkOutput("idle_strobes_busy", busy, 0);
        checkOutput("idle_strobes_done_count", done_count, 0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            repeat (2) tick();
        end

        // Reset in the middle of WAIT abandons the run without a done pulse
        saved_done = done_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        chal_ready = 1'b1;
        tick();
        chal_ready = 1'b0;
        core_done = 1'b1; core_sig = 24'h111111;
        tick();
        core_done = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkAllZero("midwait_reset");
        rsp_valid = 1'b1; rsp = 24'h111111;
        tick();
        clearInputs();
        repeat (5) tick();
        checkOutput("no_done_after_reset", done_count, saved_done);
        model_lfsr = SEED;
        applyStimulus(vecs[0]);

        repeat (3) tick();
        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("total_done_pulses", done_count, 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
